// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : mips_pkg                                                  |
// | Purpose  : Shared defaults for the MIPS register file and a helper   |
// |            that converts a data width into a byte-lane count.        |
// | Contents : DEF_DATA_WIDTH, DEF_ADDR_WIDTH, lane_count()              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package mips_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  // Number of 8-bit lanes in a word of the given width.
  function automatic int lane_count(input int data_width);
    return data_width / 8;
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_rd_port                                           |
// | Purpose  : One read port of the register file: index mux, same-cycle |
// |            write merge (optional), register-0 override and an        |
// |            optional output register.                                 |
// | Ports    : clk, rst_n        - clock, async active-low reset         |
// |            addr             - read index                            |
// |            regs             - current storage contents              |
// |            wr_en/addr/data/be - write buses, used for forwarding     |
// |            data             - read data                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module regfile_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WR     = 1,
  parameter int BYPASS     = 1,
  parameter int READ_REG   = 0,
  parameter int ZERO_REG   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 addr,
  input  logic [DATA_WIDTH-1:0]                 regs [2**ADDR_WIDTH],
  input  logic [NUM_WR-1:0]                     wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]          wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]          wr_data,
  input  logic [NUM_WR*lane_count(DATA_WIDTH)-1:0] wr_be,
  output logic [DATA_WIDTH-1:0]                 data
);

  localparam int NB = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] raw;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] value;

  assign raw = regs[addr];

  generate
    if (BYPASS != 0) begin : g_bypass
      // Overlay every enabled write lane aimed at this index, lowest port
      // first, so a higher-numbered port wins a shared lane exactly as the
      // storage update does. Writes are ignored while reset is asserted.
      always_comb begin
        merged = raw;
        if (rst_n) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
              for (int b = 0; b < NB; b++) begin
                if (wr_be[w*NB + b]) begin
                  merged[b*8 +: 8] = wr_data[w*DATA_WIDTH + b*8 +: 8];
                end
              end
            end
          end
        end
      end
    end else begin : g_no_bypass
      logic unused_wr;
      assign unused_wr = ^{wr_en, wr_addr, wr_data, wr_be};
      assign merged    = raw;
    end
  endgenerate

  // Register 0 reads as zero regardless of any forwarded write.
  always_comb begin
    value = merged;
    if ((ZERO_REG != 0) && (addr == '0)) begin
      value = '0;
    end
  end

  generate
    if (READ_REG != 0) begin : g_reg_out
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else begin
          data_q <= value;
        end
      end
      assign data = data_q;
    end else begin : g_comb_out
      logic unused_clk;
      assign unused_clk = clk;
      // Storage is already cleared during reset; gating here also hides
      // any value that would otherwise leak through the forwarding path.
      assign data = rst_n ? value : '0;
    end
  endgenerate

endmodule : regfile_rd_port
`default_nettype wire

// File: rtl/mips_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mips_regfile_mp                                           |
// | Purpose  : Multi-ported MIPS register file with byte-lane writes,    |
// |            optional write forwarding, optional registered reads and  |
// |            optional hardwired-zero register 0.                       |
// | Ports    : clk      - rising-edge clock                              |
// |            rst_n    - asynchronous active-low reset                  |
// |            rd_addr  - NUM_RD packed read indices                     |
// |            rd_data  - NUM_RD packed read words                       |
// |            wr_en    - per-port write enables                         |
// |            wr_addr  - NUM_WR packed write indices                    |
// |            wr_data  - NUM_WR packed write words                      |
// |            wr_be    - NUM_WR packed byte-lane enables                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module mips_regfile_mp
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int BYPASS     = 1,
  parameter int READ_REG   = 0,
  parameter int ZERO_REG   = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]          rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]          rd_data,
  input  logic [NUM_WR-1:0]                     wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]          wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0]          wr_data,
  input  logic [NUM_WR*lane_count(DATA_WIDTH)-1:0] wr_be
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = lane_count(DATA_WIDTH);

  generate
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH <= 0) begin : g_bad_data_width
      $error("mips_regfile_mp: DATA_WIDTH must be a positive multiple of 8");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("mips_regfile_mp: NUM_RD must be in 1..4");
    end
    if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_num_wr
      $error("mips_regfile_mp: NUM_WR must be in 1..2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] regs      [DEPTH];
  logic [DATA_WIDTH-1:0] regs_next [DEPTH];

  // Apply write ports in ascending order so a higher-numbered port
  // overrides a lower one on any lane both enable.
  always_comb begin
    regs_next = regs;
    for (int w = 0; w < NUM_WR; w++) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_en[w] && wr_be[w*NB + b]) begin
          regs_next[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] =
            wr_data[w*DATA_WIDTH + b*8 +: 8];
        end
      end
    end
    if (ZERO_REG != 0) begin
      regs_next[0] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else begin
      regs <= regs_next;
    end
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
      regfile_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WR     (NUM_WR),
        .BYPASS     (BYPASS),
        .READ_REG   (READ_REG),
        .ZERO_REG   (ZERO_REG)
      ) u_rd_port (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
        .regs    (regs),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .data    (rd_data[p*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule : mips_regfile_mp
`default_nettype wire

// File: tb/tb_mips_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_mips_regfile_mp                                        |
// | Purpose  : Self-checking bench for mips_regfile_mp. Four instances   |
// |            share one stimulus: d0 comb+bypass, d1 comb, d2 reg+bypass,|
// |            d3 reg. Expected read values are queued at drive time and |
// |            compared when each instance presents its result.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_mips_regfile_mp;

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    logic [31:0] exp;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  en;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [3:0]  be [2];
  logic [4:0]  ra [2];

  logic [9:0]  rd_addr;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_be;
  logic [63:0] rdd [4];

  assign rd_addr = {ra[1], ra[0]};
  assign wr_addr = {wa[1], wa[0]};
  assign wr_data = {wd[1], wd[0]};
  assign wr_be   = {be[1], be[0]};

  generate
    for (genvar d = 0; d < 4; d++) begin : g_dut
      mips_regfile_mp #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_RD     (2),
        .NUM_WR     (2),
        .BYPASS     ((d % 2 == 0) ? 1 : 0),
        .READ_REG   ((d >= 2) ? 1 : 0),
        .ZERO_REG   (1)
      ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (rd_addr),
        .rd_data (rdd[d]),
        .wr_en   (en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_be   (wr_be)
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model    [32];
  logic [31:0] prev_reg [4][2];
  exp_t        q_comb [$];
  exp_t        q_reg  [$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_rd(input int d, input int p);
    logic [63:0] v;
    v = rdd[d];
    return v[p*32 +: 32];
  endfunction

  // Value a read of index a should present this cycle: stored word, with
  // the current cycle's writes overlaid when forwarding is on.
  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    logic [31:0] v;
    v = model[a];
    if (byp) begin
      for (int w = 0; w < 2; w++) begin
        if (en[w] && wa[w] == a) begin
          for (int b = 0; b < 4; b++) begin
            if (be[w][b]) v[b*8 +: 8] = wd[w][b*8 +: 8];
          end
        end
      end
    end
    if (a == 5'd0) v = '0;
    return v;
  endfunction

  task automatic model_write();
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (en[w] && be[w][b] && wa[w] != 5'd0) model[wa[w]][b*8 +: 8] = wd[w][b*8 +: 8];
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int d = 0; d < 4; d++) begin
      prev_reg[d][0] = '0;
      prev_reg[d][1] = '0;
    end
  endtask

  task automatic do_cycle(input string name, input logic [1:0] e,
                          input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [3:0] b0, input logic [3:0] b1,
                          input logic [4:0] r0, input logic [4:0] r1);
    exp_t        item;
    logic [31:0] ev;
    @(negedge clk);
    en = e; wa[0] = a0; wa[1] = a1; wd[0] = d0; wd[1] = d1;
    be[0] = b0; be[1] = b1; ra[0] = r0; ra[1] = r1;
    for (int d = 0; d < 4; d++) begin
      for (int p = 0; p < 2; p++) begin
        ev        = exp_read(ra[p], (d % 2) == 0);
        item.dut  = d;
        item.port = p;
        if (d < 2) begin
          item.tag = $sformatf("%s_d%0d_p%0d", name, d, p);
          item.exp = ev;
          q_comb.push_back(item);
        end else begin
          item.tag = $sformatf("%s_d%0d_p%0d_hold", name, d, p);
          item.exp = prev_reg[d][p];
          q_comb.push_back(item);
          item.tag = $sformatf("%s_d%0d_p%0d", name, d, p);
          item.exp = ev;
          q_reg.push_back(item);
        end
      end
    end
    #3;
    while (q_comb.size() > 0) begin
      item = q_comb.pop_front();
      check_val(item.tag, get_rd(item.dut, item.port), item.exp);
    end
    @(posedge clk);
    model_write();
    #1;
    while (q_reg.size() > 0) begin
      item = q_reg.pop_front();
      check_val(item.tag, get_rd(item.dut, item.port), item.exp);
      prev_reg[item.dut][item.port] = item.exp;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    en = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    be[0] = '0; be[1] = '0; ra[0] = 5'd1; ra[1] = 5'd2;
    clear_model();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 4; d++)
      for (int p = 0; p < 2; p++)
        check_val($sformatf("reset_d%0d_p%0d", d, p), get_rd(d, p), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // r1 = 55, then attempt r0 = all-ones while reading both.
    do_cycle("wr_r1",   2'b01, 5'd1, 5'd0, 32'd55, 32'h0, 4'hF, 4'h0, 5'd1, 5'd0);
    do_cycle("wr_r0",   2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 4'hF, 5'd0, 5'd1);
    do_cycle("rd_r0r1", 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, 5'd0, 5'd1);

    // Byte-lane merge.
    do_cycle("wr_r3",   2'b01, 5'd3, 5'd0, 32'h11223344, 32'h0, 4'hF, 4'h0, 5'd3, 5'd3);
    do_cycle("be_r3",   2'b01, 5'd3, 5'd0, 32'hAABBCCDD, 32'h0, 4'b0101, 4'h0, 5'd3, 5'd3);
    do_cycle("rd_r3",   2'b00, 5'd3, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, 5'd3, 5'd3);

    // Two ports collide on r7; port 1 owns lane 1, port 0 keeps the rest.
    do_cycle("coll_r7", 2'b11, 5'd7, 5'd7, 32'h000000AA, 32'h0000BB00, 4'hF, 4'b0010, 5'd7, 5'd7);
    do_cycle("rd_r7",   2'b00, 5'd7, 5'd7, 32'h0, 32'h0, 4'h0, 4'h0, 5'd7, 5'd1);

    // Enabled write with no lanes leaves r7 alone.
    do_cycle("be0_r7",  2'b11, 5'd7, 5'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0, 4'h0, 5'd7, 5'd7);
    do_cycle("rd2_r7",  2'b00, 5'd7, 5'd7, 32'h0, 32'h0, 4'h0, 4'h0, 5'd7, 5'd7);

    // Forwarding on r9: old value 0x1111, new 0x1234.
    do_cycle("wr_r9",   2'b01, 5'd9, 5'd0, 32'h00001111, 32'h0, 4'hF, 4'h0, 5'd9, 5'd0);
    do_cycle("byp_r9",  2'b10, 5'd0, 5'd9, 32'h0, 32'h00001234, 4'h0, 4'hF, 5'd9, 5'd9);

    // Registered-read latency on r2 = 77.
    do_cycle("wr_r2",   2'b01, 5'd2, 5'd0, 32'd77, 32'h0, 4'hF, 4'h0, 5'd9, 5'd9);
    do_cycle("lat_r2",  2'b00, 5'd2, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, 5'd2, 5'd2);
    do_cycle("lat2_r2", 2'b00, 5'd2, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, 5'd1, 5'd2);

    for (int i = 0; i < 24; i++) begin
      do_cycle($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom, $urandom,
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Asynchronous reset in mid-cycle clears r5 without a clock edge.
    do_cycle("wr_r5",   2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, 5'd5, 5'd5);
    en = 2'b00; ra[0] = 5'd5; ra[1] = 5'd5;
    #1;
    check_val("pre_rst_d0", get_rd(0, 0), 32'hDEADBEEF);
    check_val("pre_rst_d1", get_rd(1, 1), 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++)
      for (int p = 0; p < 2; p++)
        check_val($sformatf("async_rst_d%0d_p%0d", d, p), get_rd(d, p), 32'h0);
    // Writes presented during reset are ignored and not forwarded.
    en = 2'b01; wa[0] = 5'd5; wd[0] = 32'h12345678; be[0] = 4'hF;
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++)
      check_val($sformatf("in_rst_wr_d%0d", d), get_rd(d, 0), 32'h0);
    en = 2'b00;
    rst_n = 1'b1;
    clear_model();
    do_cycle("post_rst", 2'b01, 5'd5, 5'd0, 32'hCAFE0001, 32'h0, 4'hF, 4'h0, 5'd5, 5'd5);
    do_cycle("rd_r5",    2'b00, 5'd5, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, 5'd5, 5'd0);
    do_cycle("idle",     2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'h0, 4'h0, 5'd3, 5'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mips_regfile_mp
`default_nettype wire
